bcd2bin_16: RTL and testbench
=============================

Name: bcd2bin_16

Overview:
Sequential BCD-to-binary converter. It is the inverse of the bin2bcd_16 stage that feeds the HEX displays.
- Takes five BCD digits, for example from a keypad or switch entry path, and produces a 16-bit unsigned binary value.
- Uses reverse double dabble: one shift-and-correct iteration per clock.
- Sits beside counter_16 so a user-entered decimal value can preload the counter or be compared against it.

Parameters:
ITER, 17, number of shift iterations. Equals the internal binary accumulator width; 17 bits covers 99999. Only 17 is supported.

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge
RESET_N  input  1  synchronous active-low reset, sampled on the CLOCK_50 rising edge
start  input  1  conversion request; sampled only while busy=0
BCD0  input  4  units digit
BCD1  input  4  tens digit
BCD2  input  4  hundreds digit
BCD3  input  4  thousands digit
BCD4  input  4  ten-thousands digit
bin  output  16  converted value, low 16 bits of the result; held until the next completed conversion
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bin, err and ovf become valid
err  output  1  an input digit exceeded 9; valid with done
ovf  output  1  decimal value exceeded 65535; valid with done

Behaviour:
- Reset (RESET_N=0 at an edge):
  - state returns to IDLE; iteration counter cleared.
  - bin=0, busy=0, done=0, err=0, ovf=0.
  - Reset overrides everything, including a conversion in progress; the aborted conversion produces no done.
- States: IDLE and CONV.
- IDLE, start=1, all digits <=9, at edge k:
  - Capture {BCD4..BCD0} into a 20-bit shift register; clear the 17-bit accumulator and the counter.
  - busy=1 and state becomes CONV.
- IDLE, start=1, any digit >9, at edge k:
  - No conversion.
  - Next cycle: done=1, err=1, ovf=0, bin=0; busy stays 0; state stays IDLE.
- CONV, each edge, one iteration:
  - Shift the 37-bit concatenation {BCD register, accumulator} right by one; the BCD LSB enters the accumulator MSB.
  - Then, for each 4-bit BCD field independently, if the field is >=8, subtract 3 from it.
  - Increment the counter.
- Completion: on the edge that performs iteration ITER (edge k+17):
  - bin = accumulator[15:0] after that iteration.
  - ovf = accumulator[16].
  - err=0, done=1, busy=0; state returns to IDLE.
  - done is therefore high in the cycle after edge k+17, i.e. 17 cycles after the capture edge.
- done:
  - Exactly one cycle wide.
  - Deasserts on the next edge unless a new invalid-digit start produces another done.
  - The first edge a new conversion can be captured is the one at which done is high.
- Timing rules:
  - start while busy=1 is ignored, not queued.
  - Digit inputs are don't-care after the capture edge.
  - start held high continuously restarts a new conversion each time IDLE is re-entered.
- Output hold:
  - bin/err/ovf hold their last values between conversions.
  - They update only together with done, or at reset.
- Arithmetic:
  - Unsigned only. Per-digit correction never borrows across fields.
  - Full range 00000..99999. Values above 65535 wrap modulo 65536 in bin, with ovf=1.

Test Plan:
1. Reset then start with digits 1,2,3,4,5 (BCD4..BCD0) -> busy high 17 cycles; done pulse; bin=0x3039, ovf=0, err=0.
2. Digits 6,5,5,3,5 -> bin=0xFFFF, ovf=0. Digits 0,0,0,0,0 -> bin=0x0000, done after 17 cycles.
3. Digits 6,5,5,3,6 -> bin=0x0000, ovf=1. Digits 9,9,9,9,9 -> bin=0x869F, ovf=1.
4. BCD2=0xA with start -> done and err=1 in the next cycle; bin=0, busy never asserts. A following valid start converts normally with err=0.
5. Start 12345, pulse start again with digits 00001 at cycle 5, change digits mid-conversion -> single done, bin=0x3039. Separately, assert RESET_N=0 at cycle 8 -> no done, all outputs 0.
6. Round trip: sweep counter values 0..65535 through bin2bcd_16 into this block -> bin equals the original value and ovf=0 for every value.

Source files
------------

// File: rtl/bcd2bin_16.sv
// Reverse double-dabble BCD-to-binary: one shift/correct step per clock, done 17 cycles after capture.
// No backpressure: start is sampled only while idle, and a start while busy is dropped, not queued.
module bcd2bin_16 #(
  parameter int ITER = 17
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        start,
  input  logic [3:0]  BCD0,
  input  logic [3:0]  BCD1,
  input  logic [3:0]  BCD2,
  input  logic [3:0]  BCD3,
  input  logic [3:0]  BCD4,
  output logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [19:0] bcd_q;
  logic [16:0] acc_q;
  logic [4:0]  cnt_q;

  logic [36:0] shifted;
  logic [19:0] bcd_nxt;
  logic [16:0] acc_nxt;
  logic        digits_ok;

  // Shift {bcd, acc} right by one, then pull each BCD field back by 3 if it reached 8.
  always_comb begin
    shifted = {1'b0, bcd_q, acc_q[16:1]};
    acc_nxt = shifted[16:0];
    bcd_nxt = shifted[36:17];
    for (int i = 0; i < 5; i++) begin
      if (bcd_nxt[4*i +: 4] >= 4'd8)
        bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
    end
  end

  assign digits_ok = (BCD0 <= 4'd9) && (BCD1 <= 4'd9) && (BCD2 <= 4'd9) &&
                     (BCD3 <= 4'd9) && (BCD4 <= 4'd9);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= IDLE;
      bcd_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (digits_ok) begin
              bcd_q <= {BCD4, BCD3, BCD2, BCD1, BCD0};
              acc_q <= '0;
              cnt_q <= '0;
              busy  <= 1'b1;
              state <= CONV;
            end else begin
              // Bad digit: report immediately without entering the shift loop.
              bin  <= '0;
              err  <= 1'b1;
              ovf  <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        CONV: begin
          bcd_q <= bcd_nxt;
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            bin   <= acc_nxt[15:0];
            ovf   <= acc_nxt[16];
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_16.sv
// Table-driven bench for bcd2bin_16 with an expected-result queue popped on each done pulse.
module tb_bcd2bin_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  d0, d1, d2, d3, d4;
  logic [15:0] bin;
  logic        busy, done, err, ovf;

  bcd2bin_16 #(.ITER(17)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start),
    .BCD0(d0), .BCD1(d1), .BCD2(d2), .BCD3(d3), .BCD4(d4),
    .bin(bin), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] d;
    logic [15:0] bin;
    logic        err;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bin;
    logic        err;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Decimal reference: plain integer arithmetic on the digits.
  function automatic exp_t model(input logic [19:0] d);
    exp_t e;
    int   val = 0;
    logic bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
      val = val * 10 + int'(d[4*i +: 4]);
    end
    e.err = bad;
    e.bin = bad ? 16'h0 : val[15:0];
    e.ovf = bad ? 1'b0 : (val > 65535);
    e.lat = bad ? 0 : 17;
    return e;
  endfunction

  task automatic convert(input string name, input logic [19:0] d, input exp_t e);
    exp_t got;
    int   busy_cnt = 0;
    bit   seen = 0;
    sb.push_back(e);
    {d4, d3, d2, d1, d0} = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    {d4, d3, d2, d1, d0} = 20'($urandom);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) begin
        seen = 1;
        if (sb.size() == 0) begin
          check({name, "_unexpected_done"}, 1, 0);
        end else begin
          got = sb.pop_front();
          check({name, "_latency"}, c, got.lat);
          check({name, "_bin"}, bin, got.bin);
          check({name, "_err"}, err, got.err);
          check({name, "_ovf"}, ovf, got.ovf);
          check({name, "_busy_at_done"}, busy, 0);
        end
      end else begin
        if (busy) busy_cnt++;
        tick();
      end
    end
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    check({name, "_busy_cycles"}, busy_cnt, e.lat);
    tick();
    check({name, "_done_width"}, done, 0);
  endtask

  vec_t tbl[9];

  initial begin
    exp_t e;
    int   n_done, c1, c2;
    logic [19:0] rd;

    tbl[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    tbl[1] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    tbl[2] = '{20'h00000, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{20'h65536, 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{20'h99999, 16'h869F, 1'b0, 1'b1};
    tbl[5] = '{20'h00A00, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    tbl[7] = '{20'h0000F, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{20'h00001, 16'h0001, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    {d4, d3, d2, d1, d0} = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_bin", bin, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_ovf", ovf, 0);
    tick();

    for (int i = 0; i < 9; i++) begin
      e.bin = tbl[i].bin;
      e.err = tbl[i].err;
      e.ovf = tbl[i].ovf;
      e.lat = tbl[i].err ? 0 : 17;
      convert($sformatf("tbl%0d", i), tbl[i].d, e);
    end

    // Outputs hold after the last conversion.
    repeat (5) tick();
    check("hold_bin", bin, 16'h0001);
    check("hold_err", err, 0);

    // Random digit sets, including occasional invalid ones.
    for (int i = 0; i < 20; i++) begin
      rd = to_bcd(int'($urandom_range(0, 99999)));
      if (i % 7 == 3) rd[4*(i % 5) +: 4] = 4'($urandom_range(10, 15));
      convert($sformatf("rand%0d", i), rd, model(rd));
    end

    // Restart attempt and digit changes while busy are ignored.
    sb.push_back(model(20'h12345));
    {d4, d3, d2, d1, d0} = 20'h12345;
    start = 1'b1;
    tick();
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        n_done++;
        check("restart_lat", c, 17);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("restart_bin", bin, e.bin);
        end
      end
      start = (c == 5);
      {d4, d3, d2, d1, d0} = (c == 5) ? 20'h00001 : 20'($urandom);
      tick();
    end
    check("restart_single_done", n_done, 1);
    sb.delete();

    // Reset in the middle of a conversion aborts it with no done.
    {d4, d3, d2, d1, d0} = 20'h12345;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) n_done++;
      rst_n = (c != 7);
      tick();
      if (c == 7) begin
        check("abort_bin", bin, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_ovf", ovf, 0);
      end
    end
    rst_n = 1'b1;
    check("abort_no_done", n_done, 0);

    // Held start: a new capture happens on the edge where done is high.
    {d4, d3, d2, d1, d0} = 20'h00042;
    start = 1'b1;
    tick();
    c1 = -1;
    c2 = -1;
    for (int c = 0; c < 60 && c2 < 0; c++) begin
      if (done) begin
        check("held_bin", bin, 16'd42);
        if (c1 < 0) c1 = c;
        else begin
          c2 = c;
          start = 1'b0;
        end
      end
      if (c2 < 0) tick();
    end
    start = 1'b0;
    check("held_first_lat", c1, 17);
    check("held_spacing", c2 - c1, 18);
    tick();
    check("held_done_width", done, 0);
    repeat (20) tick();
    check("held_no_third", busy, 0);

    // Round trip over a stride of the 16-bit range plus the top value.
    for (int v = 0; v <= 65535; v += 97) begin
      e.bin = v[15:0];
      e.err = 1'b0;
      e.ovf = 1'b0;
      e.lat = 17;
      convert($sformatf("rt%0d", v), to_bcd(v), e);
    end
    e.bin = 16'hFFFF;
    convert("rt65535", to_bcd(65535), e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
